// File: rtl/mem_arbiter_if.sv
// Shared IF/MEM-stage memory bus bundle: requester ports, completion/stall returns and the memory issue/response channel.
// slave = arbiter view, master = pipeline + memory view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;

    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_done, if_stall,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_rdata, dm_done, dm_stall,
        output mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_done, if_stall,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_rdata, dm_done, dm_stall,
        input  mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter serialising IF fetches and MEM loads/stores onto one bus.
// Latency: grant in IDLE, issue next cycle, done combinational with mem_rvalid (min 3 cycles).
// Backpressure: payload held on mem_valid until mem_ready; requesters stall until done.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_DM     = 1'b1;

    state_t      state_q;
    logic        owner_q;
    logic        discard_q;
    logic [3:0]  starve_q;
    logic [3:0]  starve_d;
    logic        mem_valid_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;

    logic rsp;
    logic flush_hit;
    logic grant_dm;
    logic grant_if;
    logic if_done;
    logic dm_done;

    assign rsp       = (state_q == WAIT) && bus.mem_rvalid;
    assign flush_hit = bus.if_flush && (owner_q == OWN_IF) && (state_q != IDLE);
    // A flush landing on the response cycle still suppresses the completion.
    assign if_done   = rsp && (owner_q == OWN_IF) && !discard_q && !bus.if_flush;
    assign dm_done   = rsp && (owner_q == OWN_DM);
    assign grant_dm  = (state_q == IDLE) && bus.dm_req &&
                       !(bus.if_req && (starve_q == STARVE_LIM));
    assign grant_if  = (state_q == IDLE) && bus.if_req && !grant_dm;

    always_comb begin
        starve_d = starve_q;
        if (grant_dm) begin
            if (!bus.if_req)
                starve_d = 4'd0;
            else if (starve_q >= STARVE_LIM)
                starve_d = STARVE_LIM;
            else
                starve_d = starve_q + 4'd1;
        end else if (grant_if) begin
            starve_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            discard_q   <= 1'b0;
            starve_q    <= 4'd0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    if (grant_dm) begin
                        owner_q     <= OWN_DM;
                        discard_q   <= 1'b0;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_be_q    <= bus.dm_be;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        state_q     <= ISSUE;
                    end else if (grant_if) begin
                        owner_q     <= OWN_IF;
                        discard_q   <= bus.if_flush;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'hF;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= 32'd0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush_hit)
                        discard_q <= 1'b1;
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        discard_q <= 1'b0;
                        state_q   <= IDLE;
                        if (if_done)
                            if_rdata_q <= bus.mem_rdata;
                        if (dm_done)
                            dm_rdata_q <= bus.mem_rdata;
                    end else if (flush_hit) begin
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign bus.if_done  = if_done;
    assign bus.if_rdata = if_done ? bus.mem_rdata : if_rdata_q;
    assign bus.if_stall = bus.if_req & ~if_done;
    assign bus.dm_done  = dm_done;
    assign bus.dm_rdata = dm_done ? bus.mem_rdata : dm_rdata_q;
    assign bus.dm_stall = bus.dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reactive memory model, issue/response scoreboards checked by a negedge monitor.
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } iss_t;

    logic clk;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int ready_delay = 0;
    int rv_delay = 1;

    iss_t        exp_iss_q[$];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_dm_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input string what);
        tests++;
        fails++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_rd = 32'h0050_0093;
            32'h0000_0200: mem_rd = 32'h00A0_0113;
            32'h0000_2000: mem_rd = 32'h1234_5678;
            default:       mem_rd = ~a;
        endcase
    endfunction

    // Memory model: mem_ready after ready_delay stalled cycles, one-cycle rvalid rv_delay cycles after accept.
    initial begin : responder
        bit          acc;
        logic [31:0] acc_addr;
        int          hold;
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        hold = 0; pend = 0; cnt = 0; paddr = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            acc = bus.mem_valid && bus.mem_ready && !rst;
            acc_addr = bus.mem_addr;
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            if (rst) begin
                pend = 0; hold = 0;
                bus.mem_ready = 1'b0;
            end else begin
                if (acc) begin
                    pend = 1; cnt = rv_delay; paddr = acc_addr; hold = 0;
                end
                if (pend) begin
                    cnt--;
                    if (cnt <= 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata = mem_rd(paddr);
                        pend = 0;
                    end
                end
                if (bus.mem_valid) begin
                    bus.mem_ready = (hold >= ready_delay);
                    hold++;
                end else begin
                    bus.mem_ready = 1'b0;
                    hold = 0;
                end
            end
        end
    end

    // Scoreboard monitor: issue payload checked every valid cycle, completions popped on done.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.if_done) begin
                if (exp_if_q.size() == 0) flag("if_done", "unexpected completion");
                else chk("if_rdata", bus.if_rdata, exp_if_q.pop_front());
            end
            if (bus.dm_done) begin
                if (exp_dm_q.size() == 0) flag("dm_done", "unexpected completion");
                else chk("dm_rdata", bus.dm_rdata, exp_dm_q.pop_front());
            end
            if (bus.mem_valid) begin
                if (exp_iss_q.size() == 0) begin
                    flag("issue", "unexpected mem_valid");
                end else begin
                    chk("mem_addr", bus.mem_addr, exp_iss_q[0].addr);
                    chk("mem_we_be", 32'({bus.mem_we, bus.mem_be}), 32'({exp_iss_q[0].we, exp_iss_q[0].be}));
                    chk("mem_wdata", bus.mem_wdata, exp_iss_q[0].wdata);
                    if (bus.mem_ready) void'(exp_iss_q.pop_front());
                end
            end
        end
    end

    task automatic push_iss(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        iss_t r;
        r.addr = a; r.we = we; r.be = be; r.wdata = wd;
        exp_iss_q.push_back(r);
    endtask

    task automatic req_if(input logic [31:0] a, input logic [31:0] exp);
        bit seen;
        seen = 0;
        exp_if_q.push_back(exp);
        bus.if_req = 1'b1;
        bus.if_addr = a;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.if_done) seen = 1;
        end
        if (!seen) flag("if_timeout", "no if_done within 200 cycles");
        @(posedge clk);
        #1 bus.if_req = 1'b0;
    endtask

    task automatic req_dm(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp);
        bit seen;
        seen = 0;
        exp_dm_q.push_back(exp);
        bus.dm_req = 1'b1;
        bus.dm_we = we;
        bus.dm_be = be;
        bus.dm_addr = a;
        bus.dm_wdata = wd;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.dm_done) seen = 1;
        end
        if (!seen) flag("dm_timeout", "no dm_done within 200 cycles");
        @(posedge clk);
        #1 bus.dm_req = 1'b0;
    endtask

    task automatic wait_accept();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_valid && bus.mem_ready) seen = 1;
        end
        if (!seen) flag("accept_timeout", "no mem_valid&mem_ready within 200 cycles");
    endtask

    task automatic wait_issue_addr(input logic [31:0] a, input logic [3:0] exp_starve, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_valid && bus.mem_addr == a) seen = 1;
        end
        if (!seen) flag(name, "issue address never seen");
        else chk(name, 32'(dut.starve_q), 32'(exp_starve));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] starve_data [5] = '{32'hFFFF_CFFF, 32'hFFFF_CFFB, 32'hFFFF_CFF7, 32'hFFFF_CFF3, 32'hFFFF_CFEF};

    initial begin
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_dones", 32'({bus.if_done, bus.dm_done}), 32'd0);
        chk("rst_rdata", bus.if_rdata | bus.dm_rdata, 32'd0);
        chk("rst_payload", bus.mem_addr | bus.mem_wdata | 32'(bus.mem_be), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        chk("rst_starve", 32'(dut.starve_q), 32'd0);
        rst = 1'b0;
        idle(2);

        // Lone fetch, cycle-accurate
        push_iss(32'h100, 1'b0, 4'hF, 32'd0);
        exp_if_q.push_back(32'h0050_0093);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        @(negedge clk);
        chk("c0_stall", 32'({bus.if_stall, bus.mem_valid}), 32'b10);
        @(negedge clk);
        chk("c1_stall", 32'({bus.if_stall, bus.mem_valid}), 32'b11);
        @(negedge clk);
        chk("c2_done", 32'({bus.if_done, bus.if_stall}), 32'b10);
        chk("c2_rdata", bus.if_rdata, 32'h0050_0093);
        @(posedge clk);
        #1 bus.if_req = 1'b0;
        @(negedge clk);
        chk("c3_hold", bus.if_rdata, 32'h0050_0093);
        chk("c3_idle", 32'({bus.if_done, bus.mem_valid}), 32'd0);
        idle(2);

        // Contention: DM first, then IF
        push_iss(32'h2000, 1'b0, 4'hF, 32'd0);
        push_iss(32'h100, 1'b0, 4'hF, 32'd0);
        fork
            req_dm(1'b0, 4'hF, 32'h2000, 32'd0, 32'h1234_5678);
            req_if(32'h100, 32'h0050_0093);
        join
        idle(2);

        // Starvation: four DM grants, then the waiting fetch wins
        for (int i = 0; i < 4; i++) push_iss(32'h3000 + 32'(4 * i), 1'b0, 4'hF, 32'd0);
        push_iss(32'h100, 1'b0, 4'hF, 32'd0);
        push_iss(32'h3010, 1'b0, 4'hF, 32'd0);
        fork
            req_if(32'h100, 32'h0050_0093);
            begin
                for (int i = 0; i < 5; i++)
                    req_dm(1'b0, 4'hF, 32'h3000 + 32'(4 * i), 32'd0, starve_data[i]);
            end
            begin
                wait_issue_addr(32'h300C, 4'd4, "starve_at_4th");
                wait_issue_addr(32'h100, 4'd0, "starve_after_if");
            end
        join
        idle(2);

        // Flush in WAIT, response two cycles later is discarded
        rv_delay = 3;
        push_iss(32'h100, 1'b0, 4'hF, 32'd0);
        push_iss(32'h200, 1'b0, 4'hF, 32'd0);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        wait_accept();
        @(posedge clk);
        #1 bus.if_flush = 1'b1; bus.if_addr = 32'h200;
        @(posedge clk);
        #1 bus.if_flush = 1'b0;
        req_if(32'h200, 32'h00A0_0113);
        idle(2);

        // Flush coinciding with mem_rvalid
        rv_delay = 1;
        push_iss(32'h100, 1'b0, 4'hF, 32'd0);
        push_iss(32'h200, 1'b0, 4'hF, 32'd0);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        wait_accept();
        @(posedge clk);
        #1 bus.if_flush = 1'b1; bus.if_addr = 32'h200;
        #2;
        chk("flush_rsp_rvalid", 32'(bus.mem_rvalid), 32'd1);
        chk("flush_rsp_done", 32'({bus.if_done, bus.if_stall}), 32'b01);
        @(posedge clk);
        #1 bus.if_flush = 1'b0;
        req_if(32'h200, 32'h00A0_0113);
        idle(2);

        // Store with 3 cycles of backpressure
        ready_delay = 3; rv_delay = 2;
        push_iss(32'h4000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        req_dm(1'b1, 4'b0011, 32'h4000, 32'hDEAD_BEEF, 32'hFFFF_BFFF);
        ready_delay = 0; rv_delay = 1;
        idle(2);

        // Async reset during WAIT with the response on the bus
        push_iss(32'h5000, 1'b0, 4'hF, 32'd0);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h5000; bus.dm_wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst_dm_done", 32'(bus.dm_done), 32'd1);
        chk("pre_rst_starve", 32'(dut.starve_q), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("arst_dones", 32'({bus.if_done, bus.dm_done}), 32'd0);
        chk("arst_state", 32'(dut.state_q), 32'd0);
        chk("arst_starve", 32'(dut.starve_q), 32'd0);
        @(posedge clk);
        #1 bus.if_req = 1'b0; bus.dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        chk("left_iss", 32'(exp_iss_q.size()), 32'd0);
        chk("left_if", 32'(exp_if_q.size()), 32'd0);
        chk("left_dm", 32'(exp_dm_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the pipelined RV32I core. It shares one unified instruction/data memory bus between the IF stage (instruction fetch) and the MEM stage (loads/stores). It serialises their requests with a valid/ready issue phase and an rvalid response phase. It produces per-requester stall signals that feed the pipeline hazard logic alongside the load-use stall and branch/jump flushes.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch waits before the fetch is forced to win. Range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_done or if_flush
- if_addr  in  32  fetch address (word aligned)
- if_flush  in  1  one-cycle pulse; discard any fetch granted or in flight
- if_rdata  out  32  fetch data, valid when if_done=1
- if_done  out  1  fetch complete (combinational with mem_rvalid)
- if_stall  out  1  if_req & ~if_done
- dm_req  in  1  data request; held with payload until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  4  byte enables (store)
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data, valid when dm_done=1
- dm_done  out  1  data access complete
- dm_stall  out  1  dm_req & ~dm_done
- mem_valid  out  1  issue request to memory
- mem_ready  in  1  memory accepts request
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/32/32  latched payload of the granted requester
- mem_rvalid  in  1  response/ack (also returned for stores); never in the cycle of acceptance
- mem_rdata  in  32  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any request is pending, pick a winner, latch its payload and owner (IF/DM), and go to ISSUE. mem_valid=0 in IDLE.
- Winner selection:
  - DM wins by default.
  - IF wins if only if_req is set, or if starve_cnt == STARVE_MAX and if_req=1.
- starve_cnt (4-bit):
  - +1 on each DM grant while if_req=1.
  - Cleared on an IF grant, or on a DM grant while if_req=0.
  - Saturates at STARVE_MAX.
- ISSUE: mem_valid=1 with the latched payload, held stable until mem_ready. On mem_valid&mem_ready go to WAIT.
- WAIT: on mem_rvalid, go to IDLE. If owner=DM, dm_done=1 and dm_rdata=mem_rdata. If owner=IF and discard=0, if_done=1 and if_rdata=mem_rdata.
- Outside a done cycle, if_rdata/dm_rdata hold the last captured value of their port.
- discard flag:
  - Set by if_flush when owner=IF in ISSUE/WAIT, or when IF is granted in that same IDLE cycle.
  - Cleared on return to IDLE.
  - A discarded transaction still completes on the bus (it cannot be aborted), but it produces no if_done.
- if_flush has no effect while DM owns the bus or in IDLE with no IF grant.
- Requesters present a new request the cycle after done. The arbiter must not re-serve the completed request, which holds because done and state→IDLE coincide.
- Store responses return mem_rdata unspecified; dm_rdata is still updated.

## Timing
- Reset values:
  - state=IDLE, mem_valid=0, if_done=0, dm_done=0
  - starve_cnt=0, discard=0, owner=IF
  - latched payload=0, if_rdata=0, dm_rdata=0
- Minimum latency: request seen at cycle 0 (IDLE) → mem_valid cycle 1 → mem_rvalid at the earliest cycle 2 → done cycle 2, i.e. 3 cycles.
- Back-to-back: the next grant is decided in the IDLE cycle after done; one idle bus cycle between transactions.
- Stall signals are combinational from req/done.
- Simultaneous events:
  - if_flush in the same cycle as mem_rvalid: response discarded, no if_done.
  - Both requests in IDLE: DM wins unless the starvation rule applies.
- Reset asserted mid-transaction: FSM returns to IDLE immediately and the outstanding response is abandoned. The memory model shares rst.

## Test plan
- Lone fetch: if_req=1, if_addr=0x100, mem_ready=1 cycle 1, mem_rvalid cycle 2 with rdata=0x00500093 → if_done=1 and if_rdata=0x00500093 in cycle 2; if_stall=1 in cycles 0–1.
- Contention: if_req and dm_req (load 0x2000) asserted together in IDLE → DM served first (dm_done with mem_rdata), then IF served; mem_addr sequence 0x2000, 0x100.
- Starvation with STARVE_MAX=4: if_req held while dm_req re-asserts every transaction → exactly 4 DM grants, then an IF grant, then starve_cnt=0.
- Flush in flight: IF granted, if_flush pulsed in WAIT, mem_rvalid 2 cycles later → no if_done. Next IDLE grants the new if_addr=0x200 and it completes normally.
- Store with backpressure: dm_we=1, dm_be=0b0011, dm_wdata=0xDEADBEEF, mem_ready low 3 cycles → mem_valid and payload stable all 3 cycles; dm_done on the ack.
- Async reset during WAIT → mem_valid=0 and all done signals 0 without waiting for a clock edge, state IDLE, starve_cnt=0.
